// File: rtl/card_shoe.sv
// Card shoe: 13 rank counters dealt by a free-running rank pointer.
// A request latches the pointer and searches upward for the first non-empty rank.
module card_shoe (
  input  logic       fast_clock,
  input  logic       resetb,
  input  logic       deal_req,
  input  logic       reshuffle,
  output logic [3:0] card,
  output logic       card_valid,
  output logic       busy,
  output logic [5:0] cards_left,
  output logic       shoe_empty
);

  typedef enum logic {
    IDLE,
    SEARCH
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] rng_q, rng_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] card_q, card_d;
  logic [2:0] count_q [1:13];
  logic [2:0] count_d [1:13];
  logic [5:0] left_q, left_d;
  logic       card_valid_q, card_valid_d;
  logic       busy_q;
  logic       empty_q;
  logic [2:0] cand_cnt;

  function automatic logic [3:0] nextRank(input logic [3:0] r);
    return (r == 4'd13) ? 4'd1 : r + 4'd1;
  endfunction

  always_comb begin
    cand_cnt = '0;
    for (int r = 1; r <= 13; r++) begin
      if (cand_q == 4'(r)) cand_cnt = count_q[r];
    end
  end

  // Reshuffle takes priority over a deal request arriving on the same IDLE edge.
  always_comb begin
    state_d      = state_q;
    rng_d        = nextRank(rng_q);
    cand_d       = cand_q;
    card_d       = card_q;
    count_d      = count_q;
    left_d       = left_q;
    card_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (reshuffle) begin
          for (int r = 1; r <= 13; r++) count_d[r] = 3'd4;
          left_d = 6'd52;
        end else if (deal_req && (left_q != 6'd0)) begin
          cand_d  = rng_q;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (cand_cnt != 3'd0) begin
          for (int r = 1; r <= 13; r++) begin
            if (cand_q == 4'(r)) count_d[r] = count_q[r] - 3'd1;
          end
          left_d       = left_q - 6'd1;
          card_d       = cand_q;
          card_valid_d = 1'b1;
          state_d      = IDLE;
        end else begin
          cand_d = nextRank(cand_q);
        end
      end
    endcase
  end

  always_ff @(posedge fast_clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= IDLE;
      rng_q        <= 4'd1;
      cand_q       <= 4'd1;
      card_q       <= 4'd0;
      for (int r = 1; r <= 13; r++) count_q[r] <= 3'd4;
      left_q       <= 6'd52;
      card_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      empty_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rng_q        <= rng_d;
      cand_q       <= cand_d;
      card_q       <= card_d;
      for (int r = 1; r <= 13; r++) count_q[r] <= count_d[r];
      left_q       <= left_d;
      card_valid_q <= card_valid_d;
      busy_q       <= (state_d == SEARCH);
      empty_q      <= (left_d == 6'd0);
    end
  end

  assign card       = card_q;
  assign card_valid = card_valid_q;
  assign busy       = busy_q;
  assign cards_left = left_q;
  assign shoe_empty = empty_q;

endmodule
